// File: rtl/rtc_apb_pkg.sv
// Shared definitions for the RTC APB requester and the RTC slave.
package rtc_apb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // RTC register map, shared with the slave
  localparam logic [ADDR_W-1:0] RTC_ADDR_TIME   = 8'h00;
  localparam logic [ADDR_W-1:0] RTC_ADDR_ALARM  = 8'h04;
  localparam logic [ADDR_W-1:0] RTC_ADDR_ADJUST = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

  // Registered command payload, driven onto the APB address/data bus
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/rtc_apb_master.sv
// Command/response to APB requester for the RTC peripheral, with a bounded wait for pready.
module rtc_apb_master
  import rtc_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [7:0]  paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata
);

  // Last wait-counter value before the transfer is abandoned
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  apb_mst_state_t    r_state;
  apb_mst_state_t    w_state_nxt;
  apb_cmd_t          r_cmd;
  apb_cmd_t          w_cmd_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_rsp_valid;

  // State register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, command capture, wait counting and response formation
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_cnt_nxt     = r_cnt;
    w_rdata_nxt   = r_rdata;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cmd_nxt.write = cmd_write;
          w_cmd_nxt.addr  = cmd_addr;
          w_cmd_nxt.wdata = cmd_wdata;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_rdata_nxt   = r_cmd.write ? '0 : prdata;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = ST_RESP;
        end else if (r_cnt >= C_CNT_LAST) begin
          w_rdata_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_RESP;
        end else if (r_cnt != C_CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and control outputs decoded from the upcoming state
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_timeout   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_cmd       <= w_cmd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rdata     <= w_rdata_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable   <= (w_state_nxt == ST_ACCESS);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;
  assign paddr       = r_cmd.addr;
  assign pwrite      = r_cmd.write;
  assign pwdata      = r_cmd.wdata;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master with a short timeout so the abort path is quick to reach.
module tb_rtc_apb_master;
  import rtc_apb_pkg::*;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int n_vec;
  int n_err;

  rtc_apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Control bits observed as {psel, penable, rsp_valid, cmd_ready}
  task automatic test_reset();
    preset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0;
    #12;
    n_vec++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_err++; $display("FAIL reset_ctrl: got %b exp 0001", {psel, penable, rsp_valid, cmd_ready});
    end
    n_vec++;
    if ({paddr, pwrite, pwdata, rsp_rdata, rsp_timeout} !== 74'd0) begin
      n_err++; $display("FAIL reset_data: paddr=%h pwrite=%b pwdata=%h rdata=%h to=%b exp all 0",
                        paddr, pwrite, pwdata, rsp_rdata, rsp_timeout);
    end
    tick();
    preset = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = RTC_ADDR_TIME; cmd_wdata = 32'h0001_0203;
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if ({psel, penable, rsp_valid, cmd_ready, pwrite} !== 5'b10001 || paddr !== 8'h00) begin
      n_err++; $display("FAIL wr_setup: ctrl=%b pwrite=%b paddr=%h exp 1000 1 00",
                        {psel, penable, rsp_valid, cmd_ready}, pwrite, paddr);
    end
    tick();
    n_vec++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1100 || pwdata !== 32'h0001_0203) begin
      n_err++; $display("FAIL wr_access: ctrl=%b pwdata=%h exp 1100 00010203",
                        {psel, penable, rsp_valid, cmd_ready}, pwdata);
    end
    tick();
    pready = 1'b0;
    n_vec++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0010 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL wr_resp: ctrl=%b to=%b rdata=%h exp 0010 0 00000000",
                        {psel, penable, rsp_valid, cmd_ready}, rsp_timeout, rsp_rdata);
    end
    tick();
    n_vec++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
      n_err++; $display("FAIL wr_idle: ctrl=%b exp 0001", {psel, penable, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_wait_states();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = RTC_ADDR_TIME; cmd_wdata = 32'h5555_AAAA;
    pready = 1'b0; prdata = 32'h1234_5678;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({psel, penable, rsp_valid} !== 3'b110 || paddr !== 8'h00 || pwrite !== 1'b0) begin
        n_err++; $display("FAIL rd_access%0d: ctrl=%b paddr=%h pwrite=%b exp 110 00 0",
                          i, {psel, penable, rsp_valid}, paddr, pwrite);
      end
      if (i == 3) begin
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    pready = 1'b0; prdata = 32'h0;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_timeout !== 1'b0) begin
      n_err++; $display("FAIL rd_resp: valid=%b rdata=%h to=%b exp 1 deadbeef 0",
                        rsp_valid, rsp_rdata, rsp_timeout);
    end
    tick();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = RTC_ADDR_ALARM; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        n_err++; $display("FAIL to_access%0d: ctrl=%b exp 110", i, {psel, penable, rsp_valid});
      end
      tick();
    end
    n_vec++;
    if ({psel, penable, rsp_valid} !== 3'b001 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL to_resp: ctrl=%b to=%b rdata=%h exp 001 1 00000000",
                        {psel, penable, rsp_valid}, rsp_timeout, rsp_rdata);
    end
    tick();
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL to_idle: valid/ready=%b exp 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = RTC_ADDR_ALARM; cmd_wdata = 32'hAAAA_0004;
    pready = 1'b1;
    tick();
    n_vec++;
    if (paddr !== 8'h04 || cmd_ready !== 1'b0 || psel !== 1'b1) begin
      n_err++; $display("FAIL b2b_setup1: paddr=%h ready=%b psel=%b exp 04 0 1", paddr, cmd_ready, psel);
    end
    cmd_addr = RTC_ADDR_ADJUST; cmd_wdata = 32'hBBBB_0008;
    tick();
    n_vec++;
    if (cmd_ready !== 1'b0 || pwdata !== 32'hAAAA_0004) begin
      n_err++; $display("FAIL b2b_access1: ready=%b pwdata=%h exp 0 aaaa0004", cmd_ready, pwdata);
    end
    tick();
    n_vec++;
    if ({rsp_valid, cmd_ready, rsp_timeout} !== 3'b100) begin
      n_err++; $display("FAIL b2b_resp1: valid/ready/to=%b exp 100", {rsp_valid, cmd_ready, rsp_timeout});
    end
    tick();
    n_vec++;
    if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
      n_err++; $display("FAIL b2b_idle: valid/ready/psel=%b exp 010", {rsp_valid, cmd_ready, psel});
    end
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if ({psel, penable, cmd_ready} !== 3'b100 || paddr !== 8'h08) begin
      n_err++; $display("FAIL b2b_setup2: ctrl=%b paddr=%h exp 100 08", {psel, penable, cmd_ready}, paddr);
    end
    tick();
    n_vec++;
    if (penable !== 1'b1 || pwdata !== 32'hBBBB_0008) begin
      n_err++; $display("FAIL b2b_access2: penable=%b pwdata=%h exp 1 bbbb0008", penable, pwdata);
    end
    tick();
    pready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_resp2: valid=%b exp 1", rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    int seen;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = RTC_ADDR_ADJUST; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_vec++;
    if (penable !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_access: penable=%b exp 1", penable);
    end
    preset = 1'b0;
    #1;
    n_vec++;
    if ({psel, penable, rsp_valid} !== 3'b000 || paddr !== 8'h00) begin
      n_err++; $display("FAIL rst_async: ctrl=%b paddr=%h exp 000 00", {psel, penable, rsp_valid}, paddr);
    end
    tick();
    preset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || psel !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_no_resp: activity cycles=%0d ready=%b exp 0 1", seen, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0C; cmd_wdata = 32'hC0C0_C0C0; pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || paddr !== 8'h0C) begin
      n_err++; $display("FAIL rst_next_cmd: valid=%b to=%b paddr=%h exp 1 0 0c", rsp_valid, rsp_timeout, paddr);
    end
    tick();
  endtask

  task automatic test_pready_glitch();
    pready = 1'b1; prdata = 32'hBADC_0FFE;
    tick();
    tick();
    n_vec++;
    if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
      n_err++; $display("FAIL gl_idle: psel/valid/ready=%b exp 001", {psel, rsp_valid, cmd_ready});
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = RTC_ADDR_ALARM;
    tick();
    cmd_valid = 1'b0;
    tick();
    pready = 1'b0;
    n_vec++;
    if ({penable, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL gl_no_early: penable/valid=%b exp 10", {penable, rsp_valid});
    end
    tick();
    pready = 1'b1; prdata = 32'h0000_CAFE;
    tick();
    pready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_CAFE) begin
      n_err++; $display("FAIL gl_capture: valid=%b rdata=%h exp 1 0000cafe", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid_transfer();
    test_pready_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
